// File: rtl/vx_mem_tag_table_pkg.sv
// Shared widths and types for the memory tag table: entry index and pending-count
// types derived from the entry count, plus small width helpers.
package vx_mem_tag_table_pkg;

  localparam int unsigned NUM_ENTRIES_DFLT = 8;

  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Narrow data buses still carry one byte-enable bit so the port never vanishes.
  function automatic int unsigned byteen_width(input int unsigned dw);
    return (dw >= 8) ? dw / 8 : 1;
  endfunction

  localparam int unsigned TAG_OUT_WIDTH_DFLT = idx_width(NUM_ENTRIES_DFLT);
  localparam int unsigned COUNT_WIDTH_DFLT   = TAG_OUT_WIDTH_DFLT + 1;

  typedef logic [TAG_OUT_WIDTH_DFLT-1:0] entry_idx_t;
  typedef logic [COUNT_WIDTH_DFLT-1:0]   entry_cnt_t;

endpackage

// File: rtl/vx_mem_tag_table_if.sv
// Request/response bundle around the tag table: upstream (wide tag) and
// downstream (entry-index tag) handshakes. slave = the table, master = its environment.
interface vx_mem_tag_table_if
  import vx_mem_tag_table_pkg::*;
#(
  parameter int unsigned TAG_IN_WIDTH  = 1,
  parameter int unsigned TAG_OUT_WIDTH = TAG_OUT_WIDTH_DFLT,
  parameter int unsigned ADDR_WIDTH    = 1,
  parameter int unsigned DATA_WIDTH    = 1,
  parameter int unsigned BYTEEN_WIDTH  = byteen_width(DATA_WIDTH)
);

  logic                     req_valid_in;
  logic                     req_ready_in;
  logic [TAG_IN_WIDTH-1:0]  req_tag_in;
  logic [ADDR_WIDTH-1:0]    req_addr_in;
  logic                     req_rw_in;
  logic [BYTEEN_WIDTH-1:0]  req_byteen_in;
  logic [DATA_WIDTH-1:0]    req_data_in;

  logic                     req_valid_out;
  logic                     req_ready_out;
  logic [TAG_OUT_WIDTH-1:0] req_tag_out;
  logic [ADDR_WIDTH-1:0]    req_addr_out;
  logic                     req_rw_out;
  logic [BYTEEN_WIDTH-1:0]  req_byteen_out;
  logic [DATA_WIDTH-1:0]    req_data_out;

  logic                     rsp_valid_in;
  logic                     rsp_ready_in;
  logic [TAG_OUT_WIDTH-1:0] rsp_tag_in;
  logic [DATA_WIDTH-1:0]    rsp_data_in;

  logic                     rsp_valid_out;
  logic                     rsp_ready_out;
  logic [TAG_IN_WIDTH-1:0]  rsp_tag_out;
  logic [DATA_WIDTH-1:0]    rsp_data_out;

  modport slave (
    input  req_valid_in, req_tag_in, req_addr_in, req_rw_in, req_byteen_in, req_data_in,
    output req_ready_in,
    output req_valid_out, req_tag_out, req_addr_out, req_rw_out, req_byteen_out, req_data_out,
    input  req_ready_out,
    input  rsp_valid_in, rsp_tag_in, rsp_data_in,
    output rsp_ready_in,
    output rsp_valid_out, rsp_tag_out, rsp_data_out,
    input  rsp_ready_out
  );

  modport master (
    output req_valid_in, req_tag_in, req_addr_in, req_rw_in, req_byteen_in, req_data_in,
    input  req_ready_in,
    input  req_valid_out, req_tag_out, req_addr_out, req_rw_out, req_byteen_out, req_data_out,
    output req_ready_out,
    output rsp_valid_in, rsp_tag_in, rsp_data_in,
    input  rsp_ready_in,
    input  rsp_valid_out, rsp_tag_out, rsp_data_out,
    output rsp_ready_out
  );

endinterface

// File: rtl/vx_free_list.sv
// Free-entry bitmap with lowest-free-index allocation. An entry freed this cycle
// becomes allocatable next cycle; allocation always reads the registered mask.
module vx_free_list
  import vx_mem_tag_table_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES = NUM_ENTRIES_DFLT,
  parameter int unsigned IDX_WIDTH   = idx_width(NUM_ENTRIES)
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 alloc_en,
  output logic [IDX_WIDTH-1:0] alloc_idx,
  output logic                 full,
  input  logic                 free_en,
  input  logic [IDX_WIDTH-1:0] free_idx,
  output logic                 free_idx_is_free
);

  logic [NUM_ENTRIES-1:0] free_mask_q;
  logic [NUM_ENTRIES-1:0] free_mask_d;

  always_comb begin
    alloc_idx = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (free_mask_q[i]) begin
        alloc_idx = IDX_WIDTH'(i);
      end
    end
  end

  assign full             = (free_mask_q == '0);
  assign free_idx_is_free = free_mask_q[free_idx];

  always_comb begin
    free_mask_d = free_mask_q;
    if (alloc_en) begin
      free_mask_d[alloc_idx] = 1'b0;
    end
    if (free_en) begin
      free_mask_d[free_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      free_mask_q <= '1;
    end else begin
      free_mask_q <= free_mask_d;
    end
  end

endmodule

// File: rtl/vx_mem_tag_table.sv
// Bounds outstanding reads by swapping the wide arbiter tag for a free entry index
// and restoring it on response. Optional counters under VX_MEM_TAG_TABLE_PERF_EN.
module vx_mem_tag_table
  import vx_mem_tag_table_pkg::*;
#(
  parameter int unsigned NUM_ENTRIES  = NUM_ENTRIES_DFLT,
  parameter int unsigned DATA_WIDTH   = 1,
  parameter int unsigned ADDR_WIDTH   = 1,
  parameter int unsigned TAG_IN_WIDTH = 1
) (
  input  logic                               clk,
  input  logic                               reset,
  vx_mem_tag_table_if.slave                  bus,
  output logic [idx_width(NUM_ENTRIES):0]    pending_count,
  output logic                               empty
`ifdef VX_MEM_TAG_TABLE_PERF_EN
  ,
  output logic [31:0]                        perf_stall_cycles,
  output logic [idx_width(NUM_ENTRIES):0]    perf_peak_pending
`endif
);

  localparam int unsigned TAG_OUT_WIDTH = idx_width(NUM_ENTRIES);
  localparam int unsigned CNT_WIDTH     = TAG_OUT_WIDTH + 1;

  logic                     full;
  logic [TAG_OUT_WIDTH-1:0] alloc_idx;
  logic                     req_ok;
  logic                     read_fire;
  logic                     rsp_fire;
  logic                     rsp_entry_free;

  logic [TAG_IN_WIDTH-1:0]  tag_ram_q [NUM_ENTRIES];
  logic [TAG_IN_WIDTH-1:0]  tag_ram_d [NUM_ENTRIES];
  logic [CNT_WIDTH-1:0]     pending_count_q;
  logic [CNT_WIDTH-1:0]     pending_count_d;

  // Writes never allocate, so only reads are held back by a full table.
  assign req_ok = bus.req_rw_in || !full;

  assign bus.req_valid_out  = reset && bus.req_valid_in && req_ok;
  assign bus.req_ready_in   = reset && bus.req_ready_out && req_ok;
  assign bus.req_tag_out    = bus.req_rw_in ? '0 : alloc_idx;
  assign bus.req_addr_out   = bus.req_addr_in;
  assign bus.req_rw_out     = bus.req_rw_in;
  assign bus.req_byteen_out = bus.req_byteen_in;
  assign bus.req_data_out   = bus.req_data_in;

  assign bus.rsp_valid_out  = reset && bus.rsp_valid_in;
  assign bus.rsp_ready_in   = reset && bus.rsp_ready_out;
  assign bus.rsp_tag_out    = tag_ram_q[bus.rsp_tag_in];
  assign bus.rsp_data_out   = bus.rsp_data_in;

  assign read_fire = bus.req_valid_in && bus.req_ready_in && !bus.req_rw_in;
  assign rsp_fire  = bus.rsp_valid_in && bus.rsp_ready_in;

  vx_free_list #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_WIDTH   (TAG_OUT_WIDTH)
  ) u_free_list (
    .clk              (clk),
    .reset            (reset),
    .alloc_en         (read_fire),
    .alloc_idx        (alloc_idx),
    .full             (full),
    .free_en          (rsp_fire),
    .free_idx         (bus.rsp_tag_in),
    .free_idx_is_free (rsp_entry_free)
  );

  always_comb begin
    tag_ram_d = tag_ram_q;
    if (read_fire) begin
      tag_ram_d[alloc_idx] = bus.req_tag_in;
    end
  end

  always_ff @(posedge clk) begin
    tag_ram_q <= tag_ram_d;
  end

  // A stray response must not wrap the count below zero.
  always_comb begin
    pending_count_d = pending_count_q;
    unique case ({read_fire, rsp_fire})
      2'b10:   pending_count_d = pending_count_q + CNT_WIDTH'(1);
      2'b01: begin
        if (pending_count_q != '0) begin
          pending_count_d = pending_count_q - CNT_WIDTH'(1);
        end
      end
      default: pending_count_d = pending_count_q;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_count_q <= '0;
    end else begin
      pending_count_q <= pending_count_d;
    end
  end

  assign pending_count = pending_count_q;
  assign empty         = (pending_count_q == '0);

`ifdef VX_MEM_TAG_TABLE_PERF_EN
  logic [31:0]          perf_stall_cycles_q;
  logic [31:0]          perf_stall_cycles_d;
  logic [CNT_WIDTH-1:0] perf_peak_pending_q;
  logic [CNT_WIDTH-1:0] perf_peak_pending_d;

  always_comb begin
    perf_stall_cycles_d = perf_stall_cycles_q;
    if (bus.req_valid_in && !bus.req_rw_in && full && (perf_stall_cycles_q != '1)) begin
      perf_stall_cycles_d = perf_stall_cycles_q + 32'd1;
    end
    perf_peak_pending_d = perf_peak_pending_q;
    if (pending_count_d > perf_peak_pending_q) begin
      perf_peak_pending_d = pending_count_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_cycles_q <= '0;
      perf_peak_pending_q <= '0;
    end else begin
      perf_stall_cycles_q <= perf_stall_cycles_d;
      perf_peak_pending_q <= perf_peak_pending_d;
    end
  end

  assign perf_stall_cycles = perf_stall_cycles_q;
  assign perf_peak_pending = perf_peak_pending_q;
`endif

  rsp_to_free_entry_a : assert property (
    @(posedge clk) disable iff (!reset) rsp_fire |-> !rsp_entry_free
  );

  pending_bound_a : assert property (
    @(posedge clk) disable iff (!reset) pending_count_q <= CNT_WIDTH'(NUM_ENTRIES)
  );

endmodule

// File: tb/tb_vx_mem_tag_table.sv
// Directed bench for vx_mem_tag_table: allocation order, full stall, write bypass,
// simultaneous alloc/free, response backpressure and mid-operation reset.
module tb_vx_mem_tag_table;
   import vx_mem_tag_table_pkg::*;

   localparam int unsigned NE = 8;
   localparam int unsigned DW = 32;
   localparam int unsigned AW = 32;
   localparam int unsigned TW = 8;
   localparam int unsigned OW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic [OW:0]   pending_count;
   logic          empty;
   int            n_assert = 0;
   int            n_fail   = 0;
`ifdef VX_MEM_TAG_TABLE_PERF_EN
   logic [31:0]   perf_stall_cycles;
   logic [OW:0]   perf_peak_pending;
`endif

   always #5 clk = ~clk;

   vx_mem_tag_table_if #(
      .TAG_IN_WIDTH (TW), .TAG_OUT_WIDTH (OW), .ADDR_WIDTH (AW), .DATA_WIDTH (DW)
   ) bus ();

   vx_mem_tag_table #(
      .NUM_ENTRIES (NE), .DATA_WIDTH (DW), .ADDR_WIDTH (AW), .TAG_IN_WIDTH (TW)
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .bus               (bus.slave),
      .pending_count     (pending_count),
      .empty             (empty)
`ifdef VX_MEM_TAG_TABLE_PERF_EN
      ,
      .perf_stall_cycles (perf_stall_cycles),
      .perf_peak_pending (perf_peak_pending)
`endif
   );

   task automatic chk(input string tag, input bit ok, input logic [63:0] obs, input logic [63:0] exp);
      n_assert++;
      if (!ok) begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      reset              = 1'b0;
      bus.req_valid_in   = 1'b1;
      bus.req_tag_in     = 8'h55;
      bus.req_addr_in    = 32'h0;
      bus.req_rw_in      = 1'b0;
      bus.req_byteen_in  = 4'h0;
      bus.req_data_in    = 32'h0;
      bus.req_ready_out  = 1'b1;
      bus.rsp_valid_in   = 1'b1;
      bus.rsp_tag_in     = 3'd0;
      bus.rsp_data_in    = 32'h0;
      bus.rsp_ready_out  = 1'b1;
      #1;
      chk("rst_req_valid_out", bus.req_valid_out === 1'b0, bus.req_valid_out, 1'b0);
      chk("rst_req_ready_in", bus.req_ready_in === 1'b0, bus.req_ready_in, 1'b0);
      chk("rst_rsp_valid_out", bus.rsp_valid_out === 1'b0, bus.rsp_valid_out, 1'b0);
      chk("rst_rsp_ready_in", bus.rsp_ready_in === 1'b0, bus.rsp_ready_in, 1'b0);
      chk("rst_pending", pending_count === 4'd0, pending_count, 4'd0);
      chk("rst_empty", empty === 1'b1, empty, 1'b1);

      @(negedge clk);
      bus.req_valid_in  = 1'b0;
      bus.rsp_valid_in  = 1'b0;
      bus.rsp_ready_out = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("post_rst_empty", empty === 1'b1, empty, 1'b1);

      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         bus.req_valid_in = 1'b1;
         bus.req_rw_in    = 1'b0;
         bus.req_tag_in   = 8'h10 + 8'(i);
         bus.req_addr_in  = 32'hA000_0000 + 32'(i);
         #1;
         chk("fill_tag_out", bus.req_tag_out === 3'(i), bus.req_tag_out, 3'(i));
         chk("fill_ready_in", bus.req_ready_in === 1'b1, bus.req_ready_in, 1'b1);
         chk("fill_addr_out", bus.req_addr_out === 32'hA000_0000 + 32'(i),
             bus.req_addr_out, 32'hA000_0000 + 32'(i));
      end
      @(negedge clk);
      bus.req_tag_in = 8'h18;
      #1;
      chk("full_pending", pending_count === 4'd8, pending_count, 4'd8);
      chk("full_ready_in", bus.req_ready_in === 1'b0, bus.req_ready_in, 1'b0);
      chk("full_valid_out", bus.req_valid_out === 1'b0, bus.req_valid_out, 1'b0);

      bus.req_rw_in     = 1'b1;
      bus.req_data_in   = 32'hDEAD_BEEF;
      bus.req_byteen_in = 4'hF;
      #1;
      chk("wr_valid_out", bus.req_valid_out === 1'b1, bus.req_valid_out, 1'b1);
      chk("wr_ready_in", bus.req_ready_in === 1'b1, bus.req_ready_in, 1'b1);
      chk("wr_tag_out", bus.req_tag_out === 3'd0, bus.req_tag_out, 3'd0);
      chk("wr_data_out", bus.req_data_out === 32'hDEAD_BEEF, bus.req_data_out, 32'hDEAD_BEEF);
      chk("wr_rw_out", bus.req_rw_out === 1'b1, bus.req_rw_out, 1'b1);
      @(negedge clk);
      bus.req_rw_in     = 1'b0;
      bus.req_tag_in    = 8'h20;
      bus.rsp_valid_in  = 1'b1;
      bus.rsp_tag_in    = 3'd3;
      bus.rsp_data_in   = 32'h1234_5678;
      bus.rsp_ready_out = 1'b1;
      #1;
      chk("wr_pending", pending_count === 4'd8, pending_count, 4'd8);
      chk("rsp3_tag_out", bus.rsp_tag_out === 8'h13, bus.rsp_tag_out, 8'h13);
      chk("rsp3_valid_out", bus.rsp_valid_out === 1'b1, bus.rsp_valid_out, 1'b1);
      chk("rsp3_data_out", bus.rsp_data_out === 32'h1234_5678, bus.rsp_data_out, 32'h1234_5678);
      chk("rsp3_read_stalled", bus.req_ready_in === 1'b0, bus.req_ready_in, 1'b0);

      @(negedge clk);
      bus.rsp_valid_in = 1'b0;
      #1;
      chk("after_free_pending", pending_count === 4'd7, pending_count, 4'd7);
      chk("after_free_ready_in", bus.req_ready_in === 1'b1, bus.req_ready_in, 1'b1);
      chk("after_free_tag_out", bus.req_tag_out === 3'd3, bus.req_tag_out, 3'd3);
      @(negedge clk);
      bus.req_valid_in = 1'b0;
      #1;
      chk("refill_pending", pending_count === 4'd8, pending_count, 4'd8);

      for (int j = 4; j < 8; j++) begin
         @(negedge clk);
         bus.rsp_valid_in = 1'b1;
         bus.rsp_tag_in   = 3'(j);
         #1;
         chk("drain_tag_out", bus.rsp_tag_out === 8'h10 + 8'(j), bus.rsp_tag_out, 8'h10 + 8'(j));
      end
      @(negedge clk);
      bus.rsp_valid_in = 1'b0;
      #1;
      chk("drained_pending", pending_count === 4'd4, pending_count, 4'd4);

      bus.req_valid_in = 1'b1;
      bus.req_tag_in   = 8'h30;
      bus.rsp_valid_in = 1'b1;
      bus.rsp_tag_in   = 3'd0;
      #1;
      chk("both_req_tag_out", bus.req_tag_out === 3'd4, bus.req_tag_out, 3'd4);
      chk("both_rsp_tag_out", bus.rsp_tag_out === 8'h10, bus.rsp_tag_out, 8'h10);
      @(negedge clk);
      bus.rsp_valid_in  = 1'b0;
      bus.req_tag_in    = 8'h31;
      bus.req_ready_out = 1'b0;
      #1;
      chk("both_pending", pending_count === 4'd4, pending_count, 4'd4);
      chk("both_next_alloc", bus.req_tag_out === 3'd0, bus.req_tag_out, 3'd0);
      chk("both_no_ready", bus.req_ready_in === 1'b0, bus.req_ready_in, 1'b0);
      bus.req_valid_in = 1'b0;

      bus.rsp_valid_in  = 1'b1;
      bus.rsp_tag_in    = 3'd2;
      bus.rsp_ready_out = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         #1;
         chk("bp_tag_out", bus.rsp_tag_out === 8'h12, bus.rsp_tag_out, 8'h12);
         chk("bp_ready_in", bus.rsp_ready_in === 1'b0, bus.rsp_ready_in, 1'b0);
         chk("bp_pending", pending_count === 4'd4, pending_count, 4'd4);
      end
      @(negedge clk);
      bus.rsp_ready_out = 1'b1;
      #1;
      chk("bp_release_ready", bus.rsp_ready_in === 1'b1, bus.rsp_ready_in, 1'b1);
      @(negedge clk);
      bus.rsp_valid_in  = 1'b0;
      bus.rsp_ready_out = 1'b0;
      bus.req_valid_in  = 1'b1;
      bus.req_ready_out = 1'b1;
      bus.req_tag_in    = 8'h40;
      #1;
      chk("bp_freed_pending", pending_count === 4'd3, pending_count, 4'd3);
      chk("realloc0_tag_out", bus.req_tag_out === 3'd0, bus.req_tag_out, 3'd0);
      @(negedge clk);
      bus.req_tag_in = 8'h41;
      #1;
      chk("realloc2_tag_out", bus.req_tag_out === 3'd2, bus.req_tag_out, 3'd2);
      @(negedge clk);
      bus.req_valid_in = 1'b0;
      #1;
      chk("realloc_pending", pending_count === 4'd5, pending_count, 4'd5);
      bus.rsp_tag_in = 3'd4;
      #1;
      chk("peek4", bus.rsp_tag_out === 8'h30, bus.rsp_tag_out, 8'h30);
      bus.rsp_tag_in = 3'd3;
      #1;
      chk("peek3", bus.rsp_tag_out === 8'h20, bus.rsp_tag_out, 8'h20);
      bus.rsp_tag_in = 3'd0;
      #1;
      chk("peek0", bus.rsp_tag_out === 8'h40, bus.rsp_tag_out, 8'h40);

      @(negedge clk);
      bus.req_valid_in  = 1'b1;
      bus.req_tag_in    = 8'h50;
      bus.rsp_valid_in  = 1'b1;
      bus.rsp_tag_in    = 3'd1;
      bus.rsp_ready_out = 1'b1;
      reset = 1'b0;
      #1;
      chk("mid_rst_req_valid_out", bus.req_valid_out === 1'b0, bus.req_valid_out, 1'b0);
      chk("mid_rst_req_ready_in", bus.req_ready_in === 1'b0, bus.req_ready_in, 1'b0);
      chk("mid_rst_rsp_valid_out", bus.rsp_valid_out === 1'b0, bus.rsp_valid_out, 1'b0);
      chk("mid_rst_rsp_ready_in", bus.rsp_ready_in === 1'b0, bus.rsp_ready_in, 1'b0);
      chk("mid_rst_pending", pending_count === 4'd0, pending_count, 4'd0);
      chk("mid_rst_empty", empty === 1'b1, empty, 1'b1);
      @(negedge clk);
      bus.rsp_valid_in  = 1'b0;
      bus.rsp_ready_out = 1'b0;
      reset = 1'b1;
      #1;
      chk("rel_empty", empty === 1'b1, empty, 1'b1);
      chk("rel_tag_out", bus.req_tag_out === 3'd0, bus.req_tag_out, 3'd0);
      chk("rel_valid_out", bus.req_valid_out === 1'b1, bus.req_valid_out, 1'b1);
      @(negedge clk);
      bus.req_valid_in = 1'b0;
      #1;
      chk("rel_pending", pending_count === 4'd1, pending_count, 4'd1);
      chk("rel_not_empty", empty === 1'b0, empty, 1'b0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/vx_mem_tag_table.md
# vx_mem_tag_table

Downstream companion of the memory request arbiter: it takes the arbiter's single merged request stream and bounds the number of outstanding reads. Each read gets a compact entry-index tag from a free list, and the wide arbiter tag is parked in an internal table. On response, the original wide tag is restored and the entry is released, so the arbiter's response demux receives exactly the tag it issued.

## Interface
- NUM_ENTRIES, 8: maximum outstanding reads; power of two, ≥2
- DATA_WIDTH, 1: request/response data width in bits; byte-enable width is DATA_WIDTH/8
- ADDR_WIDTH, 1: address width
- TAG_IN_WIDTH, 1: wide tag width from the arbiter
- TAG_OUT_WIDTH (local): log2(NUM_ENTRIES)
- clk  in  1  clock
- reset  in  1  asynchronous, active-low (asserted when 0)
- req_valid_in / req_ready_in  in/out  1  upstream request handshake
- req_tag_in  in  TAG_IN_WIDTH  wide tag
- req_addr_in, req_rw_in, req_byteen_in, req_data_in  in  ADDR_WIDTH/1/DATA_WIDTH/8/DATA_WIDTH  request payload; rw=1 is a write
- req_valid_out / req_ready_out  out/in  1  downstream request handshake
- req_tag_out  out  TAG_OUT_WIDTH  entry index for reads; 0 for writes
- req_addr_out, req_rw_out, req_byteen_out, req_data_out  out  payload passthrough
- rsp_valid_in / rsp_ready_in  in/out  1  downstream response handshake
- rsp_tag_in  in  TAG_OUT_WIDTH  entry index
- rsp_data_in  in  DATA_WIDTH  response data
- rsp_valid_out / rsp_ready_out  out/in  1  upstream response handshake
- rsp_tag_out  out  TAG_IN_WIDTH  restored wide tag
- rsp_data_out  out  DATA_WIDTH  response data
- pending_count  out  TAG_OUT_WIDTH+1  number of allocated entries
- empty  out  1  pending_count == 0

## Operation
- State:
  - free_mask[NUM_ENTRIES], reset to all ones
  - tag_ram[NUM_ENTRIES][TAG_IN_WIDTH], not reset
  - pending_count, reset to 0
- alloc_idx = lowest set bit of the registered free_mask.
- full = (free_mask == 0).
- req_valid_out = req_valid_in && (req_rw_in || !full).
- req_ready_in = req_ready_out && (req_rw_in || !full).
- Read fire (req_valid_in && req_ready_in && !req_rw_in):
  - tag_ram[alloc_idx] <= req_tag_in
  - clear free_mask[alloc_idx]
  - req_tag_out = alloc_idx
- Write fire: no allocation; writes produce no response.
- Response path is combinational:
  - rsp_valid_out = rsp_valid_in
  - rsp_ready_in = rsp_ready_out
  - rsp_tag_out = tag_ram[rsp_tag_in]
  - rsp_data_out = rsp_data_in
- Response fire: set free_mask[rsp_tag_in].
- pending_count: +1 on read fire, −1 on response fire, unchanged when both occur in the same cycle.
- Simultaneous alloc and free: allocation uses the pre-update mask. A freed entry becomes allocatable next cycle, including when full (the read stalls this cycle and fires the next).
- Response to an entry that is already free: simulation assertion error; the RTL still sets the bit and does not decrement pending_count below 0.
- Reset mid-operation: all entries freed immediately and in-flight state discarded. Responses arriving after reset release are unsupported and caught by the same assertion.

## Timing
- Request and response paths have zero latency (combinational passthrough); the only registered state is the table.
- While reset is asserted:
  - req_valid_out, rsp_valid_out, req_ready_in and rsp_ready_in are forced to 0
  - pending_count = 0, empty = 1
  - data/tag outputs are don't-care
- Valid must not depend on ready downstream. The only upstream ready→valid path is through full, which is registered.
- Full throughput: one read per cycle until NUM_ENTRIES are outstanding; writes are never throttled.

## Configuration
- VX_MEM_TAG_TABLE_PERF_EN defined adds two outputs, both cleared by reset:
  - perf_stall_cycles (32-bit, saturating): counts cycles with req_valid_in && !req_rw_in && full
  - perf_peak_pending (TAG_OUT_WIDTH+1): running maximum of pending_count
- Undefined: neither port nor counter exists.

## Structure
- Shared package vx_mem_tag_table_pkg holds the entry-index typedef and the NUM_ENTRIES-derived width constants.
- One sub-module, vx_free_list:
  - contents: free_mask, lowest-set-bit encoder, alloc/free ports, full output
  - tag_ram and the handshake logic stay in the top level

## Test plan
- Reset, then 8 reads with tags 0x10..0x17 and req_ready_out=1 → req_tag_out 0..7 in order; pending_count=8; 9th read has req_ready_in=0.
- Full, issue a write → write passes (req_valid_out=1, req_tag_out=0); pending_count stays 8.
- Full, read waiting; response with rsp_tag_in=3 → rsp_tag_out=0x13; read fires the next cycle with req_tag_out=3.
- Read fire and response (tag 0) in the same cycle with 4 pending → pending_count stays 4; entry 0 is allocatable next cycle.
- rsp_ready_out=0 with rsp_valid_in=1 for 5 cycles → entry not freed and rsp_tag_out stable; freed only on the cycle rsp_ready_out=1.
- Assert reset with 5 pending → outputs go to their reset values immediately; after release, first read gets req_tag_out=0 and empty=1 before it fires.
